// File: rtl/laser_cover_eval.sv
// laser_cover_eval: scoring stage behind the LASER circle-placement engine.
// Captures a frame of NPTS points from the shared X/Y stream. When DONE_IN
// is seen, it latches both centres and walks the buffer, one point per
// cycle, counting the points within RADIUS_SQ of either centre. The count
// is reported on COVER with a one-cycle COVER_VALID strobe.
// Optional feature macro: LASER_COVER_BEST_EN adds BEST_COVER, the running
// maximum of COVER since the last reset.
module laser_cover_eval #(
  parameter int NPTS      = 40,
  parameter int RADIUS_SQ = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PT_VALID,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       DONE_IN,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  output logic       BUSY,
  output logic [5:0] COVER,
  output logic       COVER_VALID
`ifdef LASER_COVER_BEST_EN
  ,
  output logic [5:0] BEST_COVER
`endif
);

  typedef enum logic [1:0] {S_LOAD, S_WAIT, S_EVAL, S_REPORT} state_t;

  localparam logic [5:0] LAST_IDX = 6'(NPTS - 1);
  localparam logic [8:0] THRESH   = 9'(RADIUS_SQ);

  state_t      state_q, state_d;
  logic [5:0]  wp_q, wp_d;
  logic [5:0]  ix_q, ix_d;
  logic [5:0]  acc_q, acc_d;
  logic [15:0] ctr_q, ctr_d;     // {c1x, c1y, c2x, c2y}
  logic [5:0]  cover_q, cover_d;
  logic        valid_q, valid_d;
`ifdef LASER_COVER_BEST_EN
  logic [5:0]  best_q, best_d;
`endif

  logic [7:0]  pt_mem [NPTS];    // {x, y} per point
  logic [7:0]  cur_pt;
  logic        mem_we;
  logic [8:0]  dist1, dist2;
  logic        hit;

  // Squared distance between a centre and a point, both 4-bit unsigned.
  function automatic logic [8:0] dist_sq(input logic [3:0] cx, input logic [3:0] cy,
                                         input logic [3:0] px, input logic [3:0] py);
    logic signed [4:0] dx, dy;
    logic signed [7:0] wx, wy;
    dx = $signed({1'b0, cx}) - $signed({1'b0, px});
    dy = $signed({1'b0, cy}) - $signed({1'b0, py});
    wx = 8'(dx);
    wy = 8'(dy);
    return {1'b0, 8'(wx * wx)} + {1'b0, 8'(wy * wy)};
  endfunction

  assign cur_pt = pt_mem[ix_q];
  assign dist1  = dist_sq(ctr_q[15:12], ctr_q[11:8], cur_pt[7:4], cur_pt[3:0]);
  assign dist2  = dist_sq(ctr_q[7:4],   ctr_q[3:0],  cur_pt[7:4], cur_pt[3:0]);
  assign hit    = (dist1 <= THRESH) || (dist2 <= THRESH);
  assign mem_we = (state_q == S_LOAD) && PT_VALID;

  assign BUSY        = (state_q == S_WAIT) || (state_q == S_EVAL);
  assign COVER       = cover_q;
  assign COVER_VALID = valid_q;
`ifdef LASER_COVER_BEST_EN
  assign BEST_COVER  = best_q;
`endif

  // Point buffer write port.
  // NOTE: the buffer has no reset; wp and the FSM decide which entries are
  // live, so clearing the storage would only cost reset fan-out.
  always_ff @(posedge CLK) begin
    if (mem_we) pt_mem[wp_q] <= {X, Y};
  end

  // Next-state and datapath decisions for the four-phase frame cycle.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    wp_d    = wp_q;
    ix_d    = ix_q;
    acc_d   = acc_q;
    ctr_d   = ctr_q;
    cover_d = cover_q;
    valid_d = 1'b0;
`ifdef LASER_COVER_BEST_EN
    best_d  = best_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (PT_VALID) begin
          wp_d = wp_q + 6'd1;
          if (wp_q == LAST_IDX) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (DONE_IN) begin
          ctr_d   = {C1X, C1Y, C2X, C2Y};
          ix_d    = '0;
          acc_d   = '0;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (hit) acc_d = acc_q + 6'd1;
        ix_d = ix_q + 6'd1;
        if (ix_q == LAST_IDX) state_d = S_REPORT;
      end
      S_REPORT: begin
        cover_d = acc_q;
        valid_d = 1'b1;
        wp_d    = '0;
        state_d = S_LOAD;
`ifdef LASER_COVER_BEST_EN
        if (acc_q > best_q) best_d = acc_q;
`endif
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State register with synchronous reset.
  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_LOAD;
      wp_q    <= '0;
      ix_q    <= '0;
      acc_q   <= '0;
      ctr_q   <= '0;
      cover_q <= '0;
      valid_q <= 1'b0;
`ifdef LASER_COVER_BEST_EN
      best_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      ix_q    <= ix_d;
      acc_q   <= acc_d;
      ctr_q   <= ctr_d;
      cover_q <= cover_d;
      valid_q <= valid_d;
`ifdef LASER_COVER_BEST_EN
      best_q  <= best_d;
`endif
    end
  end

endmodule

// File: tb/tb_laser_cover_eval.sv
// Testbench for laser_cover_eval: directed frames, a frame-level reference
// model checked every cycle, and literal expectations for each frame.
module tb_laser_cover_eval;

  localparam int NPTS = 40;
  localparam int RSQ  = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PT_VALID = 1'b0;
  logic [3:0] X = '0, Y = '0;
  logic       DONE_IN = 1'b0;
  logic [3:0] C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
  logic       BUSY;
  logic [5:0] COVER;
  logic       COVER_VALID;
`ifdef LASER_COVER_BEST_EN
  logic [5:0] BEST_COVER;
`endif

  laser_cover_eval #(.NPTS(NPTS), .RADIUS_SQ(RSQ)) dut (
    .CLK(CLK), .RST(RST), .PT_VALID(PT_VALID), .X(X), .Y(Y),
    .DONE_IN(DONE_IN), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .BUSY(BUSY), .COVER(COVER), .COVER_VALID(COVER_VALID)
`ifdef LASER_COVER_BEST_EN
    , .BEST_COVER(BEST_COVER)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  logic [7:0] pts[$];
  bit         armed = 0;
  bit         waiting = 0;
  bit         evaluating = 0;
  int         edge_n = 0;
  int         done_edge = 0;
  int         pend = 0;
  int         exp_cover = 0;
  bit         exp_valid = 0;
  bit         exp_busy = 0;
  int         exp_best = 0;

  function automatic int cover_count(input int ax, input int ay, input int bx, input int by);
    int n = 0;
    for (int i = 0; i < pts.size(); i++) begin
      int px = int'(pts[i][7:4]);
      int py = int'(pts[i][3:0]);
      int d1 = (ax - px) * (ax - px) + (ay - py) * (ay - py);
      int d2 = (bx - px) * (bx - px) + (by - py) * (by - py);
      if (d1 <= RSQ || d2 <= RSQ) n++;
    end
    return n;
  endfunction

  // Model update at each edge from the sampled inputs, then compare.
  always @(posedge CLK) begin
    edge_n++;
    if (RST) begin
      armed = 1;
      pts.delete();
      waiting = 0; evaluating = 0;
      exp_cover = 0; exp_valid = 0; exp_busy = 0; exp_best = 0;
    end else begin
      exp_valid = 0;
      if (evaluating) begin
        if (edge_n == done_edge + NPTS + 1) begin
          exp_cover = pend;
          exp_valid = 1;
          if (pend > exp_best) exp_best = pend;
          evaluating = 0;
          pts.delete();
        end
      end else if (waiting) begin
        if (DONE_IN) begin
          pend = cover_count(int'(C1X), int'(C1Y), int'(C2X), int'(C2Y));
          done_edge = edge_n;
          waiting = 0;
          evaluating = 1;
        end
      end else if (PT_VALID) begin
        pts.push_back({X, Y});
        if (pts.size() == NPTS) waiting = 1;
      end
      exp_busy = waiting || (evaluating && edge_n < done_edge + NPTS);
    end
    #1;
    if (armed) begin
      check("busy", BUSY, exp_busy);
      check("cover_valid", COVER_VALID, exp_valid);
      check("cover", COVER, exp_cover);
`ifdef LASER_COVER_BEST_EN
      check("best_cover", BEST_COVER, exp_best);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_pts(input int n, input logic [3:0] x, input logic [3:0] y);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      PT_VALID = 1'b1; X = x; Y = y;
    end
    @(negedge CLK);
    PT_VALID = 1'b0;
  endtask

  // Raise DONE_IN with the given centres, scramble centres after capture,
  // then wait for the strobe and check latency and count.
  task automatic run_eval(input logic [3:0] ax, input logic [3:0] ay,
                          input logic [3:0] bx, input logic [3:0] by,
                          input bit hold, input int exp_cov, input string name);
    int  n;
    bit  got;
    @(negedge CLK);
    C1X = ax; C1Y = ay; C2X = bx; C2Y = by;
    DONE_IN = 1'b1;
    @(posedge CLK);
    #2;
    if (!hold) DONE_IN = 1'b0;
    C1X = 4'($urandom); C1Y = 4'($urandom); C2X = 4'($urandom); C2Y = 4'($urandom);
    n = 0; got = 0;
    while (n < 100 && !got) begin
      @(posedge CLK);
      n++;
      #2;
      if (COVER_VALID) got = 1;
    end
    check({name, "_strobe_seen"}, got, 1);
    check({name, "_latency"}, n, NPTS + 1);
    check({name, "_cover"}, COVER, exp_cov);
    if (hold) begin
      repeat (4) @(posedge CLK);
      #2;
      check({name, "_no_retrigger_busy"}, BUSY, 0);
      DONE_IN = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check("reset_busy", BUSY, 0);
    check("reset_cover", COVER, 0);
    check("reset_valid", COVER_VALID, 0);

    // Every point on a centre.
    send_pts(NPTS, 4'd8, 4'd8);
    @(negedge CLK);
    check("loaded_busy", BUSY, 1);
    run_eval(4'd8, 4'd8, 4'd0, 4'd0, 1'b0, 40, "all_in");

    // Nothing covered; DONE_IN held through REPORT into LOAD.
    send_pts(NPTS, 4'd0, 4'd0);
    run_eval(4'd15, 4'd15, 4'd15, 4'd15, 1'b1, 0, "none_in");

    // Radius boundary, with DONE_IN asserted (ignored) during loading.
    @(negedge CLK);
    DONE_IN = 1'b1;
    send_pts(20, 4'd4, 4'd0);
    DONE_IN = 1'b0;
    send_pts(20, 4'd4, 4'd1);
    run_eval(4'd0, 4'd0, 4'd15, 4'd15, 1'b0, 20, "radius");

    // Stray PT_VALID pulses in WAIT must not be stored.
    send_pts(NPTS, 4'd15, 4'd15);
    send_pts(3, 4'd0, 4'd0);
    run_eval(4'd15, 4'd15, 4'd15, 4'd15, 1'b0, 40, "strays");

    // Reset in the middle of EVAL.
    send_pts(NPTS, 4'd3, 4'd3);
    @(negedge CLK);
    C1X = 4'd3; C1Y = 4'd3; C2X = 4'd0; C2Y = 4'd0;
    DONE_IN = 1'b1;
    @(posedge CLK);
    #2;
    DONE_IN = 1'b0;
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("midreset_busy", BUSY, 0);
    check("midreset_cover", COVER, 0);
    check("midreset_valid", COVER_VALID, 0);

    // Two frames after reset: 30 then 25 covered.
    send_pts(30, 4'd2, 4'd2);
    send_pts(10, 4'd10, 4'd10);
    run_eval(4'd0, 4'd0, 4'd15, 4'd15, 1'b0, 30, "frame30");
    send_pts(25, 4'd2, 4'd2);
    send_pts(15, 4'd10, 4'd10);
    run_eval(4'd0, 4'd0, 4'd15, 4'd15, 1'b0, 25, "frame25");
`ifdef LASER_COVER_BEST_EN
    check("best_after_two", BEST_COVER, 30);
`endif

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
